// File: rtl/sfr_xbus.sv
// rtl/sfr_xbus.sv - external SFR bridge: window decode, wait-state handshake, timeout recovery
module sfr_xbus #(
    parameter int              NCH     = 4,
    parameter int              DW      = 8,
    parameter int              LW      = 2,
    parameter logic [NCH*7-1:0] CH_BASE = {7'h7E, 7'h7C, 7'h78, 7'h74},
    parameter int              TMO     = 15
) (
    input  logic              clkcpu,
    input  logic              rst,
    input  logic [6:0]        sfraddr,
    input  logic              sfrrd,
    input  logic              sfrwe,
    input  logic [DW-1:0]     sfrwdata,
    output logic [DW-1:0]     sfrdatai,
    output logic              ext_sel,
    output logic              sfrwait,
    output logic [NCH-1:0]    ch_sel,
    output logic [LW-1:0]     ch_addr,
    output logic [DW-1:0]     ch_wdata,
    output logic [NCH-1:0]    ch_rd,
    output logic [NCH-1:0]    ch_we,
    input  logic [NCH*DW-1:0] ch_rdata,
    input  logic [NCH-1:0]    ch_ready,
    output logic              tmo_flag,
    input  logic              tmo_clr
);

    localparam int CW = (NCH > 1) ? $clog2(NCH) : 1;
    localparam int TW = (TMO > 0) ? $clog2(TMO + 1) : 1;

    typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

    state_t          state_q;
    logic [CW-1:0]   ch_q;
    logic            wr_q;
    logic [TW-1:0]   cnt_q;
    logic [DW-1:0]   rdata_q;
    logic [NCH-1:0]  sel_q;
    logic [NCH-1:0]  rd_q;
    logic [NCH-1:0]  we_q;
    logic [LW-1:0]   addr_q;
    logic [DW-1:0]   wdata_q;
    logic            tmo_q;

    logic            hit;
    logic [CW-1:0]   hit_idx;
    logic [NCH-1:0]  hit_oh;
    logic [DW-1:0]   rdata_sel;
    logic            rdy_sel;

    // Descending scan so the lowest matching window overrides higher ones.
    always_comb begin
        hit     = 1'b0;
        hit_idx = '0;
        hit_oh  = '0;
        for (int i = NCH - 1; i >= 0; i--) begin
            if (sfraddr[6:LW] == CH_BASE[i*7+LW +: 7-LW]) begin
                hit        = 1'b1;
                hit_idx    = CW'(i);
                hit_oh     = '0;
                hit_oh[i]  = 1'b1;
            end
        end
    end

    always_comb begin
        rdata_sel = '0;
        rdy_sel   = 1'b0;
        for (int i = 0; i < NCH; i++) begin
            if (ch_q == CW'(i)) begin
                rdata_sel = ch_rdata[i*DW +: DW];
                rdy_sel   = ch_ready[i];
            end
        end
    end

    always_ff @(posedge clkcpu or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            ch_q    <= '0;
            wr_q    <= 1'b0;
            cnt_q   <= '0;
            rdata_q <= '0;
            sel_q   <= '0;
            rd_q    <= '0;
            we_q    <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            tmo_q   <= 1'b0;
        end else begin
            rd_q <= '0;
            we_q <= '0;
            if (tmo_clr) tmo_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if ((sfrrd || sfrwe) && hit) begin
                        ch_q    <= hit_idx;
                        addr_q  <= sfraddr[LW-1:0];
                        wdata_q <= sfrwdata;
                        wr_q    <= sfrwe;
                        cnt_q   <= '0;
                        sel_q   <= hit_oh;
                        if (sfrwe) we_q <= hit_oh;
                        else       rd_q <= hit_oh;
                        state_q <= WAIT;
                    end
                end
                WAIT: begin
                    // Ready is checked first so a reply in the timeout cycle still wins.
                    if (rdy_sel) begin
                        if (!wr_q) rdata_q <= rdata_sel;
                        sel_q   <= '0;
                        state_q <= DONE;
                    end else if ((TMO != 0) && (cnt_q == TW'(TMO))) begin
                        if (!wr_q) rdata_q <= '1;
                        tmo_q   <= 1'b1;
                        sel_q   <= '0;
                        state_q <= DONE;
                    end else if (cnt_q != '1) begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                DONE:    state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign ext_sel  = (state_q == IDLE) ? hit : 1'b1;
    assign sfrwait  = ((state_q == IDLE) && (sfrrd || sfrwe) && hit) || (state_q == WAIT);
    assign sfrdatai = rdata_q;
    assign ch_sel   = sel_q;
    assign ch_rd    = rd_q;
    assign ch_we    = we_q;
    assign ch_addr  = addr_q;
    assign ch_wdata = wdata_q;
    assign tmo_flag = tmo_q;

endmodule

// File: tb/tb_sfr_xbus.sv
// tb/tb_sfr_xbus.sv - directed bench for sfr_xbus with default parameters
module tb_sfr_xbus;

    logic        clkcpu = 1'b0;
    logic        rst;
    logic [6:0]  sfraddr;
    logic        sfrrd;
    logic        sfrwe;
    logic [7:0]  sfrwdata;
    logic [7:0]  sfrdatai;
    logic        ext_sel;
    logic        sfrwait;
    logic [3:0]  ch_sel;
    logic [1:0]  ch_addr;
    logic [7:0]  ch_wdata;
    logic [3:0]  ch_rd;
    logic [3:0]  ch_we;
    logic [31:0] ch_rdata;
    logic [3:0]  ch_ready;
    logic        tmo_flag;
    logic        tmo_clr;

    int n_chk = 0;
    int n_err = 0;

    sfr_xbus dut (
        .clkcpu   (clkcpu),
        .rst      (rst),
        .sfraddr  (sfraddr),
        .sfrrd    (sfrrd),
        .sfrwe    (sfrwe),
        .sfrwdata (sfrwdata),
        .sfrdatai (sfrdatai),
        .ext_sel  (ext_sel),
        .sfrwait  (sfrwait),
        .ch_sel   (ch_sel),
        .ch_addr  (ch_addr),
        .ch_wdata (ch_wdata),
        .ch_rd    (ch_rd),
        .ch_we    (ch_we),
        .ch_rdata (ch_rdata),
        .ch_ready (ch_ready),
        .tmo_flag (tmo_flag),
        .tmo_clr  (tmo_clr)
    );

    always #5 clkcpu = ~clkcpu;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clkcpu);
        #1;
    endtask

    initial begin
        rst = 1'b1; sfraddr = '0; sfrrd = 1'b0; sfrwe = 1'b0; sfrwdata = '0;
        ch_rdata = '0; ch_ready = '0; tmo_clr = 1'b0;
        tick; tick; #4;
        chk("rst_datai", sfrdatai, 0);
        chk("rst_wait", sfrwait, 0);
        chk("rst_sel", ch_sel, 0);
        chk("rst_rd", ch_rd, 0);
        chk("rst_we", ch_we, 0);
        chk("rst_addr", ch_addr, 0);
        chk("rst_wdata", ch_wdata, 0);
        chk("rst_tmo", tmo_flag, 0);
        tick; rst = 1'b0;

        // zero-wait read at 0x75 (ch0 window 0x74..0x77)
        ch_rdata = 32'h0000_005A; ch_ready = 4'hF;
        tick; sfraddr = 7'h75; sfrrd = 1'b1; #4;
        chk("t1_c0_wait", sfrwait, 1);
        chk("t1_c0_ext", ext_sel, 1);
        tick; #4;
        chk("t1_c1_rd", ch_rd, 4'b0001);
        chk("t1_c1_addr", ch_addr, 1);
        chk("t1_c1_sel", ch_sel, 4'b0001);
        chk("t1_c1_wait", sfrwait, 1);
        tick; sfrrd = 1'b0; #4;
        chk("t1_c2_wait", sfrwait, 0);
        chk("t1_c2_data", sfrdatai, 8'h5A);
        chk("t1_c2_sel", ch_sel, 0);
        chk("t1_c2_rd", ch_rd, 0);
        chk("t1_c2_ext", ext_sel, 1);

        // write to ch2 with ready in WAIT cycle 3
        ch_ready = 4'b0000;
        tick; sfraddr = 7'h7C; sfrwe = 1'b1; sfrwdata = 8'hC3; #4;
        chk("t2_c0_wait", sfrwait, 1);
        tick; #4;
        chk("t2_c1_we", ch_we, 4'b0100);
        chk("t2_c1_rd", ch_rd, 0);
        chk("t2_c1_wdata", ch_wdata, 8'hC3);
        tick; ch_ready = 4'b1011; #4;
        chk("t2_c2_we", ch_we, 0);
        chk("t2_c2_wait", sfrwait, 1);
        tick; ch_ready = 4'b0100; #4;
        chk("t2_c3_wait", sfrwait, 1);
        chk("t2_c3_sel", ch_sel, 4'b0100);
        chk("t2_c3_wdata", ch_wdata, 8'hC3);
        tick; sfrwe = 1'b0; ch_ready = 4'b0000; #4;
        chk("t2_c4_wait", sfrwait, 0);
        chk("t2_c4_data", sfrdatai, 8'h5A);
        chk("t2_c4_sel", ch_sel, 0);

        // timeout on ch1, never ready
        ch_rdata = 32'h0000_3300;
        tick; sfraddr = 7'h78; sfrrd = 1'b1; #4;
        for (int k = 1; k <= 16; k++) begin
            tick; #4;
            chk($sformatf("t3_c%0d_wait", k), sfrwait, 1);
        end
        tick; sfrrd = 1'b0; #4;
        chk("t3_c17_wait", sfrwait, 0);
        chk("t3_c17_data", sfrdatai, 8'hFF);
        chk("t3_c17_tmo", tmo_flag, 1);
        tick; tmo_clr = 1'b1; #4;
        chk("t3_clr_pre", tmo_flag, 1);
        tick; tmo_clr = 1'b0; #4;
        chk("t3_clr_post", tmo_flag, 0);

        // ready coincident with the timeout cycle
        tick; sfraddr = 7'h79; sfrrd = 1'b1; #4;
        for (int k = 1; k <= 15; k++) begin
            tick; #4;
        end
        tick; ch_ready = 4'b0010; #4;
        chk("t4_c16_wait", sfrwait, 1);
        tick; sfrrd = 1'b0; ch_ready = 4'b0000; #4;
        chk("t4_c17_data", sfrdatai, 8'h33);
        chk("t4_c17_tmo", tmo_flag, 0);
        chk("t4_c17_wait", sfrwait, 0);

        // miss, then rd+we at 0x7E (overlaps ch2/ch3, ch2 wins) as a write
        tick; sfraddr = 7'h10; sfrrd = 1'b1; #4;
        chk("t5_miss_ext", ext_sel, 0);
        chk("t5_miss_wait", sfrwait, 0);
        tick; #4;
        chk("t5_miss_rd", ch_rd, 0);
        chk("t5_miss_sel", ch_sel, 0);
        tick; sfraddr = 7'h7E; sfrwe = 1'b1; sfrwdata = 8'h96; ch_ready = 4'b0100; #4;
        chk("t5_c0_ext", ext_sel, 1);
        chk("t5_c0_wait", sfrwait, 1);
        tick; #4;
        chk("t5_c1_we", ch_we, 4'b0100);
        chk("t5_c1_rd", ch_rd, 0);
        chk("t5_c1_wdata", ch_wdata, 8'h96);
        chk("t5_c1_addr", ch_addr, 2);
        tick; sfrrd = 1'b0; sfrwe = 1'b0; #4;
        chk("t5_c2_wait", sfrwait, 0);
        chk("t5_c2_data", sfrdatai, 8'h33);

        // reset in WAIT cycle 2, then a normal access
        ch_ready = 4'b0000; ch_rdata = 32'h0000_00A5;
        tick; sfraddr = 7'h74; sfrrd = 1'b1; #4;
        tick; #4;
        tick;
        chk("t6_pre_sel", ch_sel, 4'b0001);
        rst = 1'b1; sfrrd = 1'b0; #1;
        chk("t6_rst_sel", ch_sel, 0);
        chk("t6_rst_wait", sfrwait, 0);
        chk("t6_rst_data", sfrdatai, 0);
        tick; rst = 1'b0;
        ch_ready = 4'hF;
        tick; sfraddr = 7'h76; sfrrd = 1'b1; #4;
        chk("t6_c0_wait", sfrwait, 1);
        tick; #4;
        chk("t6_c1_rd", ch_rd, 4'b0001);
        chk("t6_c1_addr", ch_addr, 2);
        tick; sfrrd = 1'b0; #4;
        chk("t6_c2_data", sfrdatai, 8'hA5);
        chk("t6_c2_wait", sfrwait, 0);

        tick;
        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
